// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DIV_WIDTH_DEF : default operand width
//   DIV_CNT_W_DEF : iteration counter width for the default operand width
//   div_state_t   : controller state encoding
//   cnt_width()   : counter width for an arbitrary operand width (minimum 1 bit)
package seq_restoring_divider_pkg;

    localparam int DIV_WIDTH_DEF = 4;
    localparam int DIV_CNT_W_DEF = $clog2(DIV_WIDTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_restoring_divider_addsub_unit.sv
// Combinational N-bit ripple add/subtract unit.
//   a, b  : operands
//   m     : 0 = add, 1 = subtract (b is inverted and m is the carry-in)
//   sum   : N-bit result
//   carry : carry out of the top bit (for subtract: 1 means no borrow)
module addsub_unit #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         m,
    output logic [N-1:0] sum,
    output logic         carry
);

    logic [N:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b ^ {N{m}}} + {{N{1'b0}}, m};
    end

    assign sum   = total[N-1:0];
    assign carry = total[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one shift-subtract step per clock,
// with a start/done handshake.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request, only looked at in IDLE
//   dividend     : numerator, captured on an accepted start
//   divisor      : denominator, captured on an accepted start
//   busy         : high while iterating
//   done         : one-cycle pulse, results valid from this cycle
//   quotient     : result, held until replaced by the next result
//   remainder    : result, held until replaced by the next result
//   div_by_zero  : set with done for a zero divisor, cleared on next accepted start
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; results from the last operation held
// ST_RUN  | one restoring step per cycle, WIDTH cycles in total
// ST_DONE | single-cycle done pulse, then back to IDLE
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic             trial_neg;
    logic [WIDTH:0]   step_r;
    logic [WIDTH-1:0] step_q;
    logic             sub_carry_unused;

    // Shift the next dividend bit into the partial remainder, then trial-subtract.
    assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    addsub_unit #(
        .N (WIDTH + 1)
    ) u_addsub (
        .a     (r_shift),
        .b     ({1'b0, divisor_q}),
        .m     (1'b1),
        .sum   (trial),
        .carry (sub_carry_unused)
    );

    // The partial remainder stays below 2*divisor, so the top bit of the
    // (WIDTH+1)-bit difference is a reliable sign.
    assign trial_neg = trial[WIDTH];
    assign step_r    = trial_neg ? r_shift : trial;
    assign step_q    = {q_q[WIDTH-2:0], ~trial_neg};

    always_comb begin
        state_d       = state_q;
        r_d           = r_q;
        q_d           = q_q;
        cnt_d         = cnt_q;
        divisor_d     = divisor_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    divisor_d     = divisor;
                    r_d           = '0;
                    q_d           = dividend;
                    cnt_d         = '0;
                    div_by_zero_d = 1'b0;
                    if (divisor == '0) begin
                        state_d       = ST_DONE;
                        quotient_d    = '1;
                        remainder_d   = dividend;
                        div_by_zero_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_DONE;
                    quotient_d  = step_q;
                    remainder_d = step_r[WIDTH-1:0];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            r_q           <= '0;
            q_q           <= '0;
            cnt_q         <= '0;
            divisor_q     <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            q_q           <= q_d;
            cnt_q         <= cnt_d;
            divisor_q     <= divisor_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Behavioural reference: a countdown of remaining busy cycles and
    // results computed with plain / and %.
    int           m_cnt = 0;
    logic         e_busy = 1'b0;
    logic         e_done = 1'b0;
    logic [W-1:0] e_quo = '0;
    logic [W-1:0] e_rem = '0;
    logic         e_dbz = 1'b0;
    logic [W-1:0] p_quo = '0;
    logic [W-1:0] p_rem = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            e_busy <= 1'b0;
            e_done <= 1'b0;
            e_quo  <= '0;
            e_rem  <= '0;
            e_dbz  <= 1'b0;
            p_quo  <= '0;
            p_rem  <= '0;
        end else if (m_cnt != 0) begin
            if (m_cnt == 1) begin
                e_busy <= 1'b0;
                e_done <= 1'b1;
                e_quo  <= p_quo;
                e_rem  <= p_rem;
            end
            m_cnt <= m_cnt - 1;
        end else if (e_done) begin
            e_done <= 1'b0;
        end else if (start) begin
            if (divisor == '0) begin
                e_done <= 1'b1;
                e_quo  <= '1;
                e_rem  <= dividend;
                e_dbz  <= 1'b1;
            end else begin
                e_dbz  <= 1'b0;
                m_cnt  <= W;
                e_busy <= 1'b1;
                p_quo  <= dividend / divisor;
                p_rem  <= dividend % divisor;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #2;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #2;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
            if (done) break;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no done, expected done within 20 cycles");
        end
    endtask

    task automatic op_literal(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        int lat;
        int nb;
        launch(a, b);
        wait_done(lat, nb);
        chk({name, "_latency"}, 32'(lat), (b == '0) ? 32'd1 : 32'(W + 1));
        chk({name, "_busy_cycles"}, 32'(nb), (b == '0) ? 32'd0 : 32'(W));
        chk({name, "_quotient"}, 32'(quotient), 32'(eq));
        chk({name, "_remainder"}, 32'(remainder), 32'(er));
        chk({name, "_div_by_zero"}, 32'(div_by_zero), 32'(edbz));
    endtask

    initial begin
        int lat;
        int nb;

        fork
            forever begin
                @(negedge clk);
                chk("cyc_busy", 32'(busy), 32'(e_busy));
                chk("cyc_done", 32'(done), 32'(e_done));
                chk("cyc_quotient", 32'(quotient), 32'(e_quo));
                chk("cyc_remainder", 32'(remainder), 32'(e_rem));
                chk("cyc_div_by_zero", 32'(div_by_zero), 32'(e_dbz));
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Divide by zero, then a valid start clears the flag
        op_literal("div0_9", 4'd9, 4'd0, 4'hF, 4'd9, 1'b1);
        chk("model_div0_quo", 32'(e_quo), 32'hF);
        launch(4'd13, 4'd3);
        #1;
        chk("dbz_cleared", 32'(div_by_zero), 32'd0);
        wait_done(lat, nb);
        chk("13_3_latency", 32'(lat), 32'(W + 1));
        chk("13_3_busy_cycles", 32'(nb), 32'(W));
        chk("13_3_quotient", 32'(quotient), 32'd4);
        chk("13_3_remainder", 32'(remainder), 32'd1);
        chk("model_13_3_quo", 32'(e_quo), 32'd4);
        chk("model_13_3_rem", 32'(e_rem), 32'd1);

        op_literal("15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        op_literal("7_9", 4'd7, 4'd9, 4'd0, 4'd7, 1'b0);
        op_literal("0_5", 4'd0, 4'd5, 4'd0, 4'd0, 1'b0);

        // Start while running is ignored
        launch(4'd14, 4'd4);
        @(posedge clk);
        #2;
        start    = 1'b1;
        dividend = 4'd3;
        divisor  = 4'd1;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done(lat, nb);
        chk("14_4_latency", 32'(lat), 32'(W - 1));
        chk("14_4_quotient", 32'(quotient), 32'd3);
        chk("14_4_remainder", 32'(remainder), 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("14_4_hold_quotient", 32'(quotient), 32'd3);
            chk("14_4_hold_remainder", 32'(remainder), 32'd2);
        end

        // Reset in the middle of an operation
        launch(4'd11, 4'd2);
        @(posedge clk);
        #2;
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        chk("abort_div_by_zero", 32'(div_by_zero), 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        op_literal("11_2", 4'd11, 4'd2, 4'd5, 4'd1, 1'b0);

        // Exhaustive, back-to-back; values checked every cycle against the model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                launch(W'(a), W'(b));
                wait_done(lat, nb);
                chk("exh_latency", 32'(lat), (b == 0) ? 32'd1 : 32'(W + 1));
                if (b != 0) begin
                    chk("exh_identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
                    chk("exh_rem_lt_div", 32'(remainder < W'(b)), 32'd1);
                end
            end
        end

        // Random start pulses, operands and idle gaps
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #2;
            start    = ($urandom_range(0, 2) == 0);
            dividend = W'($urandom);
            divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        end
        start = 1'b0;
        repeat (W + 4) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
